// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage core.
// Produces per-cycle stall/flush commands for PC, IF/ID, ID/EX and EX/MEM from
// load-use hazards, EX-stage redirects and a multi-cycle MDU occupying EX.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rs1/rs2_id_i, *_used_id_i ID-stage source indices and read flags
//   *_ex_i, *_mem_i           EX / MEM stage valid, write, load flags and dest
//   redirect_ex_i             taken branch/jump resolved in EX
//   mdu_start_ex_i, mdu_done_i MDU first-EX-cycle marker and result valid
//   pc/ifid/idex_stall_o      hold commands (combinational)
//   ifid/idex/exmem_flush_o   bubble-insert commands (combinational)
//   mdu_timeout_o             one-cycle pulse on forced MDU release
//   loaduse/mdu_stall/flush_cnt_o  performance counters
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
// performance counters; otherwise the counter outputs are tied to zero.

module hazard_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id_i,
    input  logic [4:0]  rs2_id_i,
    input  logic        rs1_used_id_i,
    input  logic        rs2_used_id_i,
    input  logic        instr_valid_ex_i,
    input  logic        rf_we_ex_i,
    input  logic        is_load_ex_i,
    input  logic [4:0]  wr_ex_i,
    input  logic        instr_valid_mem_i,
    input  logic        rf_we_mem_i,
    input  logic        is_load_mem_i,
    input  logic [4:0]  wr_mem_i,
    input  logic        redirect_ex_i,
    input  logic        mdu_start_ex_i,
    input  logic        mdu_done_i,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        idex_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        exmem_flush_o,
    output logic        mdu_timeout_o,
    output logic [31:0] loaduse_cnt_o,
    output logic [31:0] mdu_stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int unsigned CW = $clog2(MDU_TIMEOUT);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdu_stall;
    logic          timeout_c;
    logic          lu_raw;
    logic          lu;
    logic          rd;

    // Load-use detection: a used, non-zero source matching a load in EX or MEM.
    always_comb begin
        lu_raw = 1'b0;
        if (rs1_used_id_i && (rs1_id_i != 5'd0)) begin
            if (instr_valid_ex_i && rf_we_ex_i && is_load_ex_i && (wr_ex_i == rs1_id_i))
                lu_raw = 1'b1;
            if (instr_valid_mem_i && rf_we_mem_i && is_load_mem_i && (wr_mem_i == rs1_id_i))
                lu_raw = 1'b1;
        end
        if (rs2_used_id_i && (rs2_id_i != 5'd0)) begin
            if (instr_valid_ex_i && rf_we_ex_i && is_load_ex_i && (wr_ex_i == rs2_id_i))
                lu_raw = 1'b1;
            if (instr_valid_mem_i && rf_we_mem_i && is_load_mem_i && (wr_mem_i == rs2_id_i))
                lu_raw = 1'b1;
        end
    end

    // MDU state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MDU next-state and stall/timeout decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu_start_ex_i && !mdu_done_i) begin
                    mdu_stall = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                end
            end
            BUSY: begin
                if (mdu_done_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(MDU_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                end else begin
                    mdu_stall = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Priority: MDU stall over redirect over load-use.
    assign rd = redirect_ex_i && !mdu_stall;
    assign lu = lu_raw && !mdu_stall && !redirect_ex_i;

    // Reset forces bubbles everywhere and releases every hold.
    assign pc_stall_o    = !rst && (mdu_stall || lu);
    assign ifid_stall_o  = !rst && (mdu_stall || lu);
    assign idex_stall_o  = !rst && mdu_stall;
    assign ifid_flush_o  = rst || rd;
    assign idex_flush_o  = rst || rd || lu;
    assign exmem_flush_o = rst || mdu_stall;
    assign mdu_timeout_o = !rst && timeout_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] lu_cnt_q, mdu_cnt_q, fl_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            mdu_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            if (lu && (lu_cnt_q != 32'hFFFF_FFFF))
                lu_cnt_q <= lu_cnt_q + 32'd1;
            if (mdu_stall && (mdu_cnt_q != 32'hFFFF_FFFF))
                mdu_cnt_q <= mdu_cnt_q + 32'd1;
            if (rd && (fl_cnt_q != 32'hFFFF_FFFF))
                fl_cnt_q <= fl_cnt_q + 32'd1;
        end
    end

    assign loaduse_cnt_o   = lu_cnt_q;
    assign mdu_stall_cnt_o = mdu_cnt_q;
    assign flush_cnt_o     = fl_cnt_q;
`else
    assign loaduse_cnt_o   = 32'd0;
    assign mdu_stall_cnt_o = 32'd0;
    assign flush_cnt_o     = 32'd0;
`endif

endmodule
